// File: rtl/serial_mac_relu_if.sv
// Handshake bundle for serial_mac_relu: start, beat input (din/weight), result output and busy.
interface serial_mac_relu_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
);
  logic              start;
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] weight;
  logic [ACC_W-1:0]  dout_relu;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;

  modport master (
    output start, din_valid, din, weight, dout_ready,
    input  din_ready, dout_relu, dout_valid, busy
  );

  modport slave (
    input  start, din_valid, din, weight, dout_ready,
    output din_ready, dout_relu, dout_valid, busy
  );
endinterface

// File: rtl/serial_mac_relu.sv
// Serial MAC neuron core: accumulates N_INPUTS unsigned*signed products, outputs ReLU'd sum.
// Optional MAC_SAT_EN: clamp positive results to all ones instead of truncating to ACC_W bits.
module serial_mac_relu #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 18
) (
  input logic              clk,
  input logic              rst_n,
  serial_mac_relu_if.slave bus
);
  localparam int PROD_W = 2*DATA_W + 1;
  localparam int CNT_W  = $clog2(N_INPUTS);
  localparam int SUM_W  = PROD_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]         dout_q, dout_d;
  logic                     valid_q, valid_d;

  logic signed [PROD_W-1:0] din_ext, w_ext, prod;
  logic signed [SUM_W-1:0]  sum;
  logic [ACC_W-1:0]         relu;

  // Operands widened to the full product width so the multiply is exact without width casts.
  assign din_ext = {{(PROD_W-DATA_W){1'b0}}, bus.din};
  assign w_ext   = {{(PROD_W-DATA_W){bus.weight[DATA_W-1]}}, bus.weight};
  assign prod    = din_ext * w_ext;
  assign sum     = acc_q + $signed({{CNT_W{prod[PROD_W-1]}}, prod});

`ifdef MAC_SAT_EN
  localparam int EXT_W = SUM_W + ACC_W;
  localparam logic [EXT_W-1:0] MAX_EXT = {{SUM_W{1'b0}}, {ACC_W{1'b1}}};
  logic [EXT_W-1:0] sum_ext;
  assign sum_ext = {{ACC_W{1'b0}}, sum};

  always_comb begin
    relu = '0;
    if (!sum[SUM_W-1]) begin
      if (sum_ext > MAX_EXT) relu = '1;
      else                   relu = sum_ext[ACC_W-1:0];
    end
  end
`else
  always_comb begin
    relu = '0;
    if (!sum[SUM_W-1]) relu = ACC_W'(sum);
  end
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        if (bus.din_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_OUT;
            dout_d  = relu;
            valid_d = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (bus.dout_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.din_ready  = (state_q == S_ACCUM);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.dout_relu  = dout_q;
  assign bus.dout_valid = valid_q;
endmodule
